// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared constants, the two-digit BCD type and the digit-increment helpers
//   used by the 12-hour time keeper and its button conditioners.
//   No ports (package).
package clock_pkg;

  localparam int RESET_HOUR_TENS = 1;
  localparam int RESET_HOUR_ONES = 2;
  localparam int MIN_TENS_MAX    = 5;
  localparam int BCD_MAX         = 9;
  localparam int SEC_MAX         = 59;

  // Board defaults; modules recompute widths from their own parameters.
  localparam int DEFAULT_CLK_FREQ_HZ     = 100_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int PRESCALE_W              = $clog2(DEFAULT_CLK_FREQ_HZ);
  localparam int DEBOUNCE_W              = $clog2(DEFAULT_DEBOUNCE_CYCLES + 1);

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Minutes 00..59 -> next value, wrapping 59 -> 00.
  function automatic bcd2_t min_inc(input bcd2_t m);
    bcd2_t r;
    r = m;
    if (m.ones == 4'(BCD_MAX)) begin
      r.ones = 4'd0;
      r.tens = (m.tens == 4'(MIN_TENS_MAX)) ? 4'd0 : m.tens + 4'd1;
    end else begin
      r.ones = m.ones + 4'd1;
    end
    return r;
  endfunction

  // Hours follow 12, 01, 02 .. 11, 12.
  function automatic bcd2_t hour_inc(input bcd2_t h);
    bcd2_t r;
    r = h;
    if (h.tens == 4'(RESET_HOUR_TENS) && h.ones == 4'(RESET_HOUR_ONES)) begin
      r.tens = 4'd0;
      r.ones = 4'd1;
    end else if (h.ones == 4'(BCD_MAX)) begin
      r.tens = 4'd1;
      r.ones = 4'd0;
    end else begin
      r.ones = h.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic logic is_min_59(input bcd2_t m);
    return (m.tens == 4'(MIN_TENS_MAX)) && (m.ones == 4'(BCD_MAX));
  endfunction

  // 11 -> 12 is the only hour step that flips AM/PM.
  function automatic logic is_hour_11(input bcd2_t h);
    return (h.tens == 4'd1) && (h.ones == 4'd1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner
//   Raw push-button -> 2-FF synchroniser -> stable-level debouncer ->
//   rising-edge one-shot. Press-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1.
// Ports
//   clk         in  system clock
//   reset       in  synchronous, active-high
//   btn_raw     in  asynchronous button level
//   press_pulse out one-cycle pulse per accepted press
module button_conditioner
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Reset treats the button as already held. A button really held through
  // reset therefore never looks like a fresh press; an idle button settles
  // to 0 after the debounce time without producing a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1      <= 1'b1;
      sync_2      <= 1'b1;
      stable      <= 1'b1;
      stable_d    <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_1      <= btn_raw;
      sync_2      <= sync_1;
      stable_d    <= stable;
      press_pulse <= stable & ~stable_d;
      // cnt counts consecutive samples that disagree with the accepted level;
      // the DEBOUNCE_CYCLES-th one flips the accepted level.
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_keeper_12h.sv
// time_keeper_12h
//   12-hour wall clock (hh:mm AM/PM) as four BCD digits for a 4-digit
//   seven-segment display, with hour/minute set buttons.
// Ports
//   clk, reset    clock, synchronous active-high reset
//   run           1 = time advances, 0 = frozen (buttons still act)
//   btn_hour      raw button, advance hour
//   btn_min       raw button, advance minute (clears seconds, no hour carry)
//   D0..D3        minutes ones, minutes tens, hours ones, hours tens
//   pm            0 = AM, 1 = PM
//   colon         high for the first half of each second
//   sec_tick      one-cycle pulse at each second boundary
module time_keeper_12h
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       btn_hour,
  input  logic       btn_min,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic       pm,
  output logic       colon,
  output logic       sec_tick
);

  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_FREQ_HZ - 1);
  localparam logic [PW-1:0] PRESCALE_HALF = PW'(CLK_FREQ_HZ / 2);

  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_next;
  logic [5:0]    sec;
  bcd2_t         mins;
  bcd2_t         hours;

  logic hour_pulse;
  logic min_pulse;
  logic btn_event;
  logic tick_adv;
  logic sec_wrap;
  logic min_step;
  logic hour_step;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hour_btn (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_hour),
    .press_pulse (hour_pulse)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_min_btn (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_min),
    .press_pulse (min_pulse)
  );

  assign sec_tick = run && (prescaler == PRESCALE_LAST);

  // A button pulse swallows a coincident second tick entirely, so a set
  // operation never races a carry in the same cycle.
  assign btn_event = hour_pulse | min_pulse;
  assign tick_adv  = sec_tick & ~btn_event;
  assign sec_wrap  = tick_adv & (sec == 6'(SEC_MAX));
  assign min_step  = min_pulse | sec_wrap;
  assign hour_step = hour_pulse | (sec_wrap & is_min_59(mins));

  always_comb begin
    prescaler_next = prescaler;
    if (run) begin
      prescaler_next = (prescaler == PRESCALE_LAST) ? '0 : prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      colon      <= 1'b1;
      sec        <= '0;
      mins       <= '0;
      hours.tens <= 4'(RESET_HOUR_TENS);
      hours.ones <= 4'(RESET_HOUR_ONES);
      pm         <= 1'b0;
    end else begin
      prescaler <= prescaler_next;
      // Computed from the next count so colon lines up with the count itself.
      colon     <= (prescaler_next < PRESCALE_HALF);

      if (min_pulse) begin
        sec <= '0;
      end else if (tick_adv) begin
        sec <= sec_wrap ? 6'd0 : sec + 6'd1;
      end

      if (min_step) begin
        mins <= min_inc(mins);
      end

      if (hour_step) begin
        hours <= hour_inc(hours);
        if (is_hour_11(hours)) begin
          pm <= ~pm;
        end
      end
    end
  end

  assign D0 = mins.ones;
  assign D1 = mins.tens;
  assign D2 = hours.ones;
  assign D3 = hours.tens;

endmodule
